// File: rtl/tuse_tnew_hazard_unit_pkg.sv
// Shared encodings and helpers for the Tuse/Tnew stall/forward controller.
// Widths here are upper bounds; the unit slices them down to its own TW.
package tuse_tnew_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    localparam int TW_MAX = 8;

    // All-ones Tuse marks a source the instruction does not read.
    localparam logic [TW_MAX-1:0] TUSE_NONE = '1;

    function automatic logic [TW_MAX-1:0] sat_dec(input logic [TW_MAX-1:0] v);
        return (v == '0) ? v : v - TW_MAX'(1);
    endfunction

endpackage

// File: rtl/tuse_tnew_hazard_unit_if.sv
// Decode-side bundle between the decoder (master) and the hazard unit (slave).
interface tuse_tnew_hazard_unit_if #(
    parameter int RA_W = 5,
    parameter int TW   = 2
);
    logic            d_valid;
    logic [RA_W-1:0] d_rs;
    logic [RA_W-1:0] d_rt;
    logic [TW-1:0]   d_rs_tuse;
    logic [TW-1:0]   d_rt_tuse;
    logic [RA_W-1:0] d_wa;
    logic [TW-1:0]   d_tnew;
    logic            d_md_start;
    logic            d_md_div;
    logic            d_md_use;

    logic            stall;
    logic            pc_en;
    logic            d_en;
    logic            e_clr;
    logic [1:0]      fwd_rs_d;
    logic [1:0]      fwd_rt_d;
    logic [1:0]      fwd_rs_e;
    logic [1:0]      fwd_rt_e;
    logic            fwd_rt_m;
    logic            md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_wa, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, pc_en, d_en, e_clr, fwd_rs_d, fwd_rt_d,
               fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_wa, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, pc_en, d_en, e_clr, fwd_rs_d, fwd_rt_d,
               fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

endinterface

// File: rtl/tuse_tnew_hazard_unit_md_busy_ctr.sv
// Multiply/divide busy timer: loads a latency when an md op enters E,
// then counts down; busy while nonzero.
module tuse_tnew_hazard_unit_md_busy_ctr
    import tuse_tnew_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/tuse_tnew_hazard_unit.sv
// Stall/forward controller for the F/D/E/M/W pipeline, driven by decoder Tuse/Tnew.
// Keeps a shadow of producer info for E, M and W and compares D/E/M sources against it.
module tuse_tnew_hazard_unit
    import tuse_tnew_hazard_unit_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    tuse_tnew_hazard_unit_if.slave  hz
);

    localparam logic [TW-1:0] TUSE_NO = TUSE_NONE[TW-1:0];

    typedef struct packed {
        logic [RA_W-1:0] wa;
        logic [TW-1:0]   tnew;
    } prod_t;

    localparam prod_t NO_PROD = '0;

    // E keeps both sources, M only rt (store data), W only its producer info.
    prod_t           e_prod_q, e_prod_d;
    logic [RA_W-1:0] e_rs_q, e_rs_d;
    logic [RA_W-1:0] e_rt_q, e_rt_d;
    prod_t           m_prod_q, m_prod_d;
    logic [RA_W-1:0] m_rt_q, m_rt_d;
    prod_t           w_prod_q, w_prod_d;

    logic             stall;
    logic             md_busy;
    logic             md_load;
    logic [CNT_W-1:0] md_load_val;

    function automatic logic [TW-1:0] tnew_step(input logic [TW-1:0] t);
        return TW'(sat_dec(TW_MAX'(t)));
    endfunction

    // Youngest of E/M wins; an older match behind it is irrelevant.
    function automatic logic src_hazard(
        input logic [RA_W-1:0] src,
        input logic [TW-1:0]   tuse,
        input prod_t           e,
        input prod_t           m
    );
        logic haz;
        haz = 1'b0;
        if ((src != '0) && (tuse != TUSE_NO)) begin
            if (e.wa == src) begin
                haz = (e.tnew > tuse);
            end else if (m.wa == src) begin
                haz = (m.tnew > tuse);
            end
        end
        return haz;
    endfunction

    function automatic logic [1:0] fwd_pick(
        input logic [RA_W-1:0] src,
        input logic            see_e,
        input prod_t           e,
        input prod_t           m,
        input prod_t           w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (see_e && (e.wa == src)) begin
                sel = (e.tnew == '0) ? FWD_E : FWD_RF;
            end else if (m.wa == src) begin
                sel = (m.tnew == '0) ? FWD_M : FWD_RF;
            end else if (w.wa == src) begin
                sel = (w.tnew == '0) ? FWD_W : FWD_RF;
            end
        end
        return sel;
    endfunction

    always_comb begin
        stall = 1'b0;
        if (hz.d_valid) begin
            stall = src_hazard(hz.d_rs, hz.d_rs_tuse, e_prod_q, m_prod_q)
                  | src_hazard(hz.d_rt, hz.d_rt_tuse, e_prod_q, m_prod_q)
                  | (hz.d_md_use & md_busy);
        end
    end

    assign hz.stall   = stall;
    assign hz.pc_en   = ~stall;
    assign hz.d_en    = ~stall;
    assign hz.e_clr   = stall;
    assign hz.md_busy = md_busy;

    assign hz.fwd_rs_d = hz.d_valid ? fwd_pick(hz.d_rs, 1'b1, e_prod_q, m_prod_q, w_prod_q) : FWD_RF;
    assign hz.fwd_rt_d = hz.d_valid ? fwd_pick(hz.d_rt, 1'b1, e_prod_q, m_prod_q, w_prod_q) : FWD_RF;
    assign hz.fwd_rs_e = fwd_pick(e_rs_q, 1'b0, e_prod_q, m_prod_q, w_prod_q);
    assign hz.fwd_rt_e = fwd_pick(e_rt_q, 1'b0, e_prod_q, m_prod_q, w_prod_q);
    assign hz.fwd_rt_m = (m_rt_q != '0) && (w_prod_q.wa == m_rt_q) && (w_prod_q.tnew == '0);

    always_comb begin
        w_prod_d      = m_prod_q;
        w_prod_d.tnew = tnew_step(m_prod_q.tnew);
        m_prod_d      = e_prod_q;
        m_prod_d.tnew = tnew_step(e_prod_q.tnew);
        m_rt_d        = e_rt_q;
        e_prod_d      = NO_PROD;
        e_rs_d        = '0;
        e_rt_d        = '0;
        if (hz.d_valid && !stall) begin
            e_prod_d.wa   = hz.d_wa;
            e_prod_d.tnew = hz.d_tnew;
            e_rs_d        = hz.d_rs;
            e_rt_d        = hz.d_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_prod_q <= NO_PROD;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_prod_q <= NO_PROD;
            m_rt_q   <= '0;
            w_prod_q <= NO_PROD;
        end else begin
            e_prod_q <= e_prod_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_prod_q <= m_prod_d;
            m_rt_q   <= m_rt_d;
            w_prod_q <= w_prod_d;
        end
    end

    assign md_load     = hz.d_valid & hz.d_md_start & ~stall;
    assign md_load_val = hz.d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    tuse_tnew_hazard_unit_md_busy_ctr #(
        .CNT_W (CNT_W)
    ) u_md_busy_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val (md_load_val),
        .busy     (md_busy)
    );

endmodule
